// File: rtl/ring_pkg.sv
// Shared widths, packet field positions and hop helpers for the ring router node.
package ring_pkg;

    localparam int unsigned PKT_W   = 64;
    localparam int unsigned VC_BIT  = 0;
    localparam int unsigned HOP_MSB = 8;
    localparam int unsigned HOP_LSB = 15;

    // Hop is stored MSB at bit 8; shifting right moves each bit toward bit 15.
    function automatic logic [PKT_W-1:0] hop_shift(input logic [PKT_W-1:0] pkt);
        logic [PKT_W-1:0] r;
        r = pkt;
        r[HOP_LSB:HOP_MSB+1] = pkt[HOP_LSB-1:HOP_MSB];
        r[HOP_MSB] = 1'b0;
        return r;
    endfunction

    function automatic logic hop_zero(input logic [PKT_W-1:0] pkt);
        return pkt[HOP_LSB:HOP_MSB] == '0;
    endfunction

endpackage

// File: rtl/ring_vc_buf.sv
// Single-packet buffer: one data register plus full flag.
module ring_vc_buf
    import ring_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [PKT_W-1:0] wdata,
    output logic             full,
    output logic [PKT_W-1:0] data
);

    // Data is kept after a read so the output mirrors the last contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else if (wr) begin
            full <= 1'b1;
            data <= wdata;
        end else if (rd) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/ring_router_node.sv
// Clockwise ring node: per-VC input/output buffers, time-shared by polarity
// between external link transfers (VC !p) and internal moves (VC p).
module ring_router_node
    import ring_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    output logic             polarity,
    input  logic             cwsi,
    output logic             cwri,
    input  logic [PKT_W-1:0] cwdi,
    output logic             cwso,
    input  logic             cwro,
    output logic [PKT_W-1:0] cwdo,
    input  logic             pesi,
    output logic             peri,
    input  logic [PKT_W-1:0] pedi,
    output logic             peso,
    input  logic             pero,
    output logic [PKT_W-1:0] pedo
);

    logic             ri_full [2];
    logic             pi_full [2];
    logic             ro_full [2];
    logic             po_full [2];
    logic [PKT_W-1:0] ri_data [2];
    logic [PKT_W-1:0] pi_data [2];
    logic [PKT_W-1:0] ro_data [2];
    logic [PKT_W-1:0] po_data [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) polarity <= 1'b0;
        else        polarity <= !polarity;
    end

    for (genvar v = 0; v < 2; v++) begin : g_vc
        localparam logic VC = 1'(v);

        logic             ext;
        logic             act;
        logic             prio;
        logic             fwd_req;
        logic             inj_req;
        logic             ej_go;
        logic             fwd_go;
        logic             inj_go;
        logic [PKT_W-1:0] ro_wdata;

        assign ext      = (polarity != VC);
        assign act      = (polarity == VC);
        assign fwd_req  = act && ri_full[v] && !hop_zero(ri_data[v]);
        assign inj_req  = act && pi_full[v];
        assign ej_go    = act && ri_full[v] && hop_zero(ri_data[v]) && !po_full[v];
        assign fwd_go   = !ro_full[v] && fwd_req && (!inj_req || !prio);
        assign inj_go   = !ro_full[v] && inj_req && (!fwd_req || prio);
        assign ro_wdata = inj_go ? pi_data[v] : hop_shift(ri_data[v]);

        // Round-robin bit only advances when both sources competed.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)                                             prio <= 1'b0;
            else if (!ro_full[v] && fwd_req && inj_req)             prio <= !prio;
        end

        ring_vc_buf u_ring_in (
            .clk(clk), .reset(reset),
            .wr(ext && cwsi && !ri_full[v]), .rd(ej_go || fwd_go),
            .wdata(cwdi), .full(ri_full[v]), .data(ri_data[v])
        );
        ring_vc_buf u_pe_in (
            .clk(clk), .reset(reset),
            .wr(ext && pesi && !pi_full[v]), .rd(inj_go),
            .wdata(pedi), .full(pi_full[v]), .data(pi_data[v])
        );
        ring_vc_buf u_ring_out (
            .clk(clk), .reset(reset),
            .wr(fwd_go || inj_go), .rd(ext && cwro && ro_full[v]),
            .wdata(ro_wdata), .full(ro_full[v]), .data(ro_data[v])
        );
        ring_vc_buf u_pe_out (
            .clk(clk), .reset(reset),
            .wr(ej_go), .rd(ext && pero && po_full[v]),
            .wdata(ri_data[v]), .full(po_full[v]), .data(po_data[v])
        );
    end

    // External side always looks at the VC opposite the current polarity.
    assign cwri = !(polarity ? ri_full[0] : ri_full[1]);
    assign peri = !(polarity ? pi_full[0] : pi_full[1]);
    assign cwso = cwro && (polarity ? ro_full[0] : ro_full[1]);
    assign peso = pero && (polarity ? po_full[0] : po_full[1]);
    assign cwdo = polarity ? ro_data[0] : ro_data[1];
    assign pedo = polarity ? po_data[0] : po_data[1];

endmodule
